multiplier_seq: RTL and testbench
=================================

Name: multiplier_seq

Overview:
- Sequential rv32m multiply execution unit for the kianv multicycle core.
- Consumes the MULop/mul_valid request produced by the multiplier decoder and performs the multiply with a radix-2 shift-add datapath.
- Returns the 32-bit rd result with a one-cycle mul_ready pulse.
- Sits beside the divider in the execute stage; the control FSM stalls on mul_ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported by the core, other values are for bench use.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rs1  input  XLEN  multiplicand, register source 1.
- rs2  input  XLEN  multiplier, register source 2.
- MULop  input  `MUL_OP_WIDTH  operation select: MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULSU, MUL_OP_MULU.
- mul_valid  input  1  request; held high by the control FSM until mul_ready is seen.
- mul_ready  output  1  one-cycle completion pulse.
- rd  output  XLEN  result; stable from mul_ready until the next accept.

Behaviour:
- Reset (async, active-high): state=IDLE, mul_ready=0, rd=0, all internal registers 0. Reset mid-operation aborts immediately; no ready pulse is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - mul_valid=1 at an edge accepts the request: latch MULop.
  - Latch |rs1| into the 64-bit multiplicand register. rs1 is treated as signed for MUL, MULH and MULSU.
  - Latch |rs2| into the 32-bit multiplier register. rs2 is treated as signed for MUL and MULH only.
  - Latch negate = sign(rs1) XOR sign(rs2), using the signedness above. Clear the 64-bit accumulator and the iteration counter. Go to CALC.
- CALC, each edge:
  - If multiplier[0], accumulator += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter++.
  - After the 32nd iteration, go to DONE. rd is written at that same edge from the sign-corrected 64-bit product: low word for MUL, high word for MULH, MULSU and MULU. Sign correction is two's-complement negation of the full 64 bits when negate=1.
- DONE: mul_ready=1 for exactly one cycle, then go to IDLE unconditionally. mul_valid is ignored while in DONE.
- Latency: mul_ready is high in the cycle following the 32nd edge after the accepting edge.
- Handshake: the control FSM drops mul_valid in the cycle after it sees mul_ready. A request still high in IDLE starts a new operation. Operands and MULop are don't-care after the accept edge.
- mul_valid=1 while in CALC is ignored; no re-latch occurs.
- Arithmetic: unsigned magnitude multiply, modulo 2^64.
  - |0x80000000| is 0x80000000 as an unsigned magnitude; no overflow.
  - MUL is sign-agnostic in the low word.
- An undefined MULop value while mul_valid=1 cannot occur; the decoder gates mul_valid.

Optional Feature:
- Macro: KIANV_MUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, the state goes to DONE at the edge where the post-shift multiplier register becomes zero.
  - Latency becomes data-dependent: iterations = index of the highest set bit of |rs2| + 1, minimum 1 (rs2=0 gives 1 edge).
  - Result is identical to the undefined case.
- Undefined: fixed 32 iterations; counter-only termination.

Decomposition:
- Shared riscv_defines.vh holds:
  - MUL_OP_WIDTH and the MUL_OP_MUL/MULH/MULSU/MULU encodings, shared with the decoder.
  - The IDLE/CALC/DONE state encodings.
- No sub-module: abs/negate and the shift-add datapath are small enough to stay inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> rd=0xFFFFFFEB; mul_ready high exactly one cycle, 32 edges after accept (macro undefined).
- MULH rs1=rs2=0x80000000 -> rd=0x40000000; MULU rs1=rs2=0xFFFFFFFF -> rd=0xFFFFFFFE.
- MULSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) -> rd=0xFFFFFFFF. Same operands with MUL -> rd=0x00000001.
- Reset asserted during CALC iteration 10 -> rd=0 and mul_ready=0 in the same cycle; after release, MUL 3x5 -> rd=15, with no stale ready pulse.
- mul_valid held high through DONE and one extra cycle -> exactly one ready per accepted request; rd stays stable between the ready pulse and the next accept.
- KIANV_MUL_EARLY_EXIT_EN defined:
  - MUL 5x2 -> rd=10 with ready after 2 CALC edges.
  - MUL 5x0 -> rd=0 after 1 CALC edge.
  - MULU 1x0x80000000 -> 32 edges.
  - Undefined: all three cases take 32 edges.

Source files
------------

// File: rtl/multiplier_seq_pkg.sv
// ----------------------------------------------------------------------------
// multiplier_seq_pkg
// Shared definitions for the sequential RV32M multiply unit: the MULop
// encodings (common with the multiplier decoder) and the FSM state codes.
// Optional build macro used by the top: KIANV_MUL_EARLY_EXIT_EN.
// ----------------------------------------------------------------------------
package multiplier_seq_pkg;

    localparam int MUL_OP_WIDTH = 2;

    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL   = 2'd0;  // low word
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH  = 2'd1;  // high, s x s
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULSU = 2'd2;  // high, s x u
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULU  = 2'd3;  // high, u x u

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/multiplier_seq_if.sv
// ----------------------------------------------------------------------------
// multiplier_seq_if
// Request/response bundle between the execute-stage control FSM (master)
// and the multiply unit (slave).
//   rs1, rs2   : operands            (master -> slave)
//   MULop      : operation select    (master -> slave)
//   mul_valid  : request, held until mul_ready is seen (master -> slave)
//   mul_ready  : one-cycle completion pulse (slave -> master)
//   rd         : result, stable from mul_ready to next accept (slave -> master)
// ----------------------------------------------------------------------------
interface multiplier_seq_if
    import multiplier_seq_pkg::*;
#(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]         rs1;
    logic [XLEN-1:0]         rs2;
    logic [MUL_OP_WIDTH-1:0] MULop;
    logic                    mul_valid;
    logic                    mul_ready;
    logic [XLEN-1:0]         rd;

    modport master (
        output rs1, rs2, MULop, mul_valid,
        input  mul_ready, rd
    );

    modport slave (
        input  rs1, rs2, MULop, mul_valid,
        output mul_ready, rd
    );
endinterface

// File: rtl/multiplier_seq.sv
// ----------------------------------------------------------------------------
// multiplier_seq
// Sequential RV32M multiply (MUL/MULH/MULSU/MULU) using a radix-2 shift-add
// datapath on operand magnitudes, with a final two's-complement sign fix.
//   clk    : core clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : multiplier_seq_if.slave (rs1, rs2, MULop, mul_valid -> mul_ready, rd)
// Build option: KIANV_MUL_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running XLEN iterations.
// ----------------------------------------------------------------------------
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic           clk,
    input  logic           reset,
    multiplier_seq_if.slave bus
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [1:0]              r_state;
    logic [MUL_OP_WIDTH-1:0] r_op;
    logic [2*XLEN-1:0]       r_mcand;
    logic [2*XLEN-1:0]       r_acc;
    logic [XLEN-1:0]         r_mplier;
    logic [CW-1:0]           r_cnt;
    logic                    r_neg;
    logic [XLEN-1:0]         r_rd;

    logic                    w_rs1_sgn;
    logic                    w_rs2_sgn;
    logic                    w_rs1_neg;
    logic                    w_rs2_neg;
    logic [XLEN-1:0]         w_rs1_abs;
    logic [XLEN-1:0]         w_rs2_abs;
    logic [2*XLEN-1:0]       w_acc_add;
    logic [2*XLEN-1:0]       w_acc_next;
    logic [XLEN-1:0]         w_mplier_next;
    logic [2*XLEN-1:0]       w_prod;
    logic [XLEN-1:0]         w_res;
    logic                    w_cnt_last;
    logic                    w_last;

    // Operand signedness: rs1 signed unless MULU, rs2 signed for MUL/MULH.
    assign w_rs1_sgn = (bus.MULop != MUL_OP_MULU);
    assign w_rs2_sgn = (bus.MULop == MUL_OP_MUL) || (bus.MULop == MUL_OP_MULH);
    assign w_rs1_neg = w_rs1_sgn & bus.rs1[XLEN-1];
    assign w_rs2_neg = w_rs2_sgn & bus.rs2[XLEN-1];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign w_rs1_abs = w_rs1_neg ? -bus.rs1 : bus.rs1;
    assign w_rs2_abs = w_rs2_neg ? -bus.rs2 : bus.rs2;

    assign w_acc_add     = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next    = r_acc + w_acc_add;
    assign w_mplier_next = r_mplier >> 1;

    // Result is taken from the accumulator value being written this edge,
    // so rd lands on the same edge as the final iteration.
    assign w_prod = r_neg ? -w_acc_next : w_acc_next;
    assign w_res  = (r_op == MUL_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_cnt_last = (r_cnt == CW'(XLEN - 1));

`ifdef KIANV_MUL_EARLY_EXIT_EN
    // No set bits left means no further additions can change the product.
    assign w_last = w_cnt_last || (w_mplier_next == '0);
`else
    assign w_last = w_cnt_last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_rd     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mul_valid) begin
                        r_op     <= bus.MULop;
                        r_mcand  <= {{XLEN{1'b0}}, w_rs1_abs};
                        r_mplier <= w_rs2_abs;
                        r_neg    <= w_rs1_neg ^ w_rs2_neg;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_rd    <= w_res;
                        r_state <= S_DONE;
                    end
                end
                // DONE always returns to IDLE; a still-high request is
                // only seen once back in IDLE.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mul_ready = (r_state == S_DONE);
    assign bus.rd        = r_rd;

endmodule

// File: tb/tb_multiplier_seq.sv
// ----------------------------------------------------------------------------
// tb_multiplier_seq
// Directed bench for multiplier_seq. A reference model predicts mul_ready and
// rd every cycle from plain 64-bit arithmetic and a latency countdown; the
// directed cases additionally pin hand-computed results and latencies.
// ----------------------------------------------------------------------------
module tb_multiplier_seq;
    import multiplier_seq_pkg::*;

`ifdef KIANV_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multiplier_seq_if #(.XLEN(32)) bus ();

    multiplier_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_rd(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op != MUL_OP_MULU) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == MUL_OP_MUL || op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(logic [1:0] op, logic [31:0] b);
        logic [31:0] m;
        int l;
        if (!EARLY) return 32;
        m = ((op == MUL_OP_MUL || op == MUL_OP_MULH) && b[31]) ? -b : b;
        l = 1;
        for (int i = 0; i < 32; i++) if (m[i]) l = i + 1;
        return l;
    endfunction

    bit          m_busy;
    bit          m_ready;
    int          m_cnt;
    logic [31:0] m_res;
    logic [31:0] m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_ready = 0; m_cnt = 0; m_rd = '0; m_res = '0;
        end else if (m_ready) begin
            m_ready = 0;                      // completion cycle; request ignored
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy = 0; m_ready = 1; m_rd = m_res;
            end
        end else if (bus.mul_valid) begin
            m_busy = 1;
            m_cnt  = model_lat(bus.MULop, bus.rs2);
            m_res  = model_rd(bus.MULop, bus.rs1, bus.rs2);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        n_tests++;
        if (bus.mul_ready !== m_ready) begin
            n_fail++;
            $display("FAIL cyc_ready t=%0t got %b want %b", $time, bus.mul_ready, m_ready);
        end
        n_tests++;
        if (bus.rd !== m_rd) begin
            n_fail++;
            $display("FAIL cyc_rd t=%0t got %h want %h", $time, bus.rd, m_rd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic start(logic [1:0] op, logic [31:0] a, logic [31:0] b, bit hold);
        @(negedge clk);
        bus.MULop = op; bus.rs1 = a; bus.rs2 = b; bus.mul_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.mul_valid = 1'b0;
    endtask

    task automatic wait_ready(output int edges, output bit ok);
        edges = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus.mul_ready) begin ok = 1; break; end
            edges++;
        end
    endtask

    task automatic run(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp_rd, int exp_lat);
        int e; bit ok;
        start(op, a, b, 1'b0);
        wait_ready(e, ok);
        chk({name, "_seen"}, 32'(ok), 32'd1);
        chk({name, "_lat"}, e, exp_lat);
        chk({name, "_rd"}, bus.rd, exp_rd);
        @(negedge clk); #1;
        chk({name, "_pulse1"}, 32'(bus.mul_ready), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e; bit ok;
        bus.mul_valid = 1'b0; bus.MULop = MUL_OP_MUL; bus.rs1 = '0; bus.rs2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd", bus.rd, 32'h0);
        chk("reset_ready", 32'(bus.mul_ready), 32'd0);
        #1 rst = 1'b0;

        run("mul_7xm3",   MUL_OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, EARLY ? 2 : 32);
        run("mulh_min",   MUL_OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 32);
        run("mulu_max",   MUL_OP_MULU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
        run("mulsu_m1",   MUL_OP_MULSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
        run("mul_m1m1",   MUL_OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, EARLY ? 1 : 32);
        run("mul_5x2",    MUL_OP_MUL,   32'd5,        32'd2,        32'd10,       EARLY ? 2 : 32);
        run("mul_5x0",    MUL_OP_MUL,   32'd5,        32'd0,        32'd0,        EARLY ? 1 : 32);
        run("mulu_1xmsb", MUL_OP_MULU,  32'd1,        32'h80000000, 32'h0,        32);
        run("mulh_neg",   MUL_OP_MULH,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, EARLY ? 2 : 32);

        // Request held through DONE and the following IDLE cycle: a second
        // operation starts, and each request yields exactly one pulse.
        start(MUL_OP_MUL, 32'd6, 32'd7, 1'b1);
        wait_ready(e, ok);
        chk("hold1_seen", 32'(ok), 32'd1);
        chk("hold1_rd", bus.rd, 32'd42);
        @(negedge clk);
        @(posedge clk); #1;
        bus.mul_valid = 1'b0;
        wait_ready(e, ok);
        chk("hold2_seen", 32'(ok), 32'd1);
        chk("hold2_lat", e, EARLY ? 3 : 32);
        chk("hold2_rd", bus.rd, 32'd42);
        @(negedge clk); #1;
        chk("hold2_pulse1", 32'(bus.mul_ready), 32'd0);

        // Reset during CALC iteration 10 aborts with no pulse.
        start(MUL_OP_MUL, 32'h1234, 32'h5678, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_rd", bus.rd, 32'h0);
        chk("abort_ready", 32'(bus.mul_ready), 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        run("mul_3x5", MUL_OP_MUL, 32'd3, 32'd5, 32'd15, EARLY ? 3 : 32);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
